udp_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UDP transmit port (w_req/w_ack/w_enable/w_data) of the UDP core between N packet sources such as video-to-UDP packetizers. It forwards one source's request to the UDP core and returns the core's acknowledge to that source only. It then passes that source's packet words through until the packet ends, and recovers from sources that stall after being acknowledged.

---
 rtl/udp_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_udp_tx_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing the UDP core's single transmit port among N packet
// sources: forwards one request, routes the acknowledge back, then passes the burst.
module udp_tx_arbiter #(
    parameter int unsigned N       = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      s_w_req,
    output logic [N-1:0]      s_w_ack,
    input  logic [N-1:0]      s_w_enable,
    input  logic [32*N-1:0]   s_w_data,
    output logic              m_w_req,
    input  logic              m_w_ack,
    output logic              m_w_enable,
    output logic [31:0]       m_w_data,
    output logic [2:0]        grant_id,
    output logic              busy,
    output logic [15:0]       timeout_cnt
);
    localparam int unsigned DW = 32;
    localparam int unsigned GW = 3;
    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam int unsigned TW = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT_EN = 3'd2,
        PASS    = 3'd3,
        GAP     = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [GW-1:0]   last;
    logic [CW-1:0]   wait_cnt;
    logic            wait_done;
    logic            sel_req;
    logic            sel_en;
    logic [DW-1:0]   sel_data;
    logic [GW-1:0]   rr_pick;
    logic            rr_found;
    logic            fwd;

    // Signals of the currently granted source
    always_comb begin
        sel_req  = 1'b0;
        sel_en   = 1'b0;
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_id == GW'(i)) begin
                sel_req  = s_w_req[i];
                sel_en   = s_w_enable[i];
                sel_data = s_w_data[DW*i +: DW];
            end
        end
    end

    // First requester after the last released source, wrapping modulo N
    always_comb begin
        rr_pick  = last;
        rr_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!rr_found && s_w_req[(int'(last) + k) % N]) begin
                rr_found = 1'b1;
                rr_pick  = GW'((int'(last) + k) % N);
            end
        end
    end

    assign wait_done = (wait_cnt == CW'(TIMEOUT - 1));
    assign fwd       = (state == WAIT_EN) || (state == PASS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (rr_found) state_nxt = REQ;
            // Acknowledge wins over a same-cycle withdrawal
            REQ:     if (m_w_ack) state_nxt = WAIT_EN;
                     else if (!sel_req) state_nxt = IDLE;
            WAIT_EN: if (sel_en) state_nxt = PASS;
                     else if (wait_done) state_nxt = GAP;
            PASS:    if (!sel_en) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_w_req = (state == REQ);
        busy    = (state != IDLE);
        s_w_ack = '0;
        if (state == REQ) begin
            for (int i = 0; i < N; i++) begin
                if (grant_id == GW'(i)) s_w_ack[i] = m_w_ack;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last        <= GW'(N - 1);
            grant_id    <= '0;
            wait_cnt    <= '0;
            timeout_cnt <= '0;
        end else begin
            if (state == IDLE && rr_found) grant_id <= rr_pick;
            if (state == GAP) last <= grant_id;
            if (state == WAIT_EN) wait_cnt <= wait_cnt + CW'(1);
            else wait_cnt <= '0;
            if (state == WAIT_EN && !sel_en && wait_done && timeout_cnt != {TW{1'b1}})
                timeout_cnt <= timeout_cnt + TW'(1);
        end
    end

    // One-cycle registered word path from the granted source
    always_ff @(posedge clk) begin
        if (rst) begin
            m_w_enable <= 1'b0;
            m_w_data   <= '0;
        end else begin
            m_w_enable <= fwd && sel_en;
            m_w_data   <= fwd ? sel_data : '0;
        end
    end
endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Bench for udp_tx_arbiter: directed scenarios plus random source agents, all
// checked every cycle against a behavioural model of the arbitration rules.
module tb_udp_tx_arbiter;
    localparam int unsigned N  = 3;
    localparam int unsigned TO = 8;
    localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_PASS = 3, P_GAP = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      s_w_req, s_w_ack, s_w_enable;
    logic [32*N-1:0]   s_w_data;
    logic              m_w_req, m_w_ack, m_w_enable;
    logic [31:0]       m_w_data;
    logic [2:0]        grant_id;
    logic              busy;
    logic [15:0]       timeout_cnt;

    udp_tx_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .s_w_req(s_w_req), .s_w_ack(s_w_ack),
        .s_w_enable(s_w_enable), .s_w_data(s_w_data),
        .m_w_req(m_w_req), .m_w_ack(m_w_ack),
        .m_w_enable(m_w_enable), .m_w_data(m_w_data),
        .grant_id(grant_id), .busy(busy), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Behavioural model: phase, grant, rotation pointer, wait deadline by cycle number
    int          ph = P_IDLE, mlast = N - 1, mg = 0, mto = 0, wstart = 0, cyc_no = 0, pick;
    logic        exp_en = 1'b0;
    logic [31:0] exp_dat = '0;
    bit          model_ok = 1'b0;

    function automatic int rr_choose(input int lst, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) if (req[(lst + k) % N]) return (lst + k) % N;
        return -1;
    endfunction

    always @(posedge clk) begin
        cyc_no++;
        if (rst) begin
            ph = P_IDLE; mlast = N - 1; mg = 0; mto = 0;
            exp_en = 1'b0; exp_dat = '0; model_ok = 1'b1;
        end else if (model_ok) begin
            if (ph == P_WAIT || ph == P_PASS) begin
                exp_en  = s_w_enable[mg];
                exp_dat = s_w_data[32*mg +: 32];
            end else begin
                exp_en  = 1'b0;
                exp_dat = '0;
            end
            case (ph)
                P_IDLE: begin
                    pick = rr_choose(mlast, s_w_req);
                    if (pick >= 0) begin mg = pick; ph = P_REQ; end
                end
                P_REQ: begin
                    if (m_w_ack) begin ph = P_WAIT; wstart = cyc_no; end
                    else if (!s_w_req[mg]) ph = P_IDLE;
                end
                P_WAIT: begin
                    if (s_w_enable[mg]) ph = P_PASS;
                    else if (cyc_no - wstart == TO) begin
                        ph = P_GAP;
                        if (mto < 65535) mto++;
                    end
                end
                P_PASS: if (!s_w_enable[mg]) ph = P_GAP;
                P_GAP:  begin mlast = mg; ph = P_IDLE; end
                default: ph = P_IDLE;
            endcase
        end
    end

    int out_words = 0;
    int beef_hits = 0;
    bit watch = 1'b0;

    always @(negedge clk) begin
        if (model_ok) begin
            check("m_w_req", m_w_req, ph == P_REQ);
            check("busy", busy, ph != P_IDLE);
            check("grant_id", grant_id, mg);
            check("s_w_ack", s_w_ack, (ph == P_REQ && m_w_ack) ? (1 << mg) : 0);
            check("m_w_enable", m_w_enable, exp_en);
            check("m_w_data", m_w_data, exp_dat);
            check("timeout_cnt", timeout_cnt, mto);
            if (m_w_enable) out_words++;
            if (watch && (m_w_data == 32'hDEADBEEF || s_w_ack[1])) beef_hits++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request to the core, check the grant, acknowledge it
    task automatic grant_ack(input int g, input bit drop, output int gap);
        gap = 0;
        while (m_w_req !== 1'b1 && gap < 20) begin cyc(); gap++; end
        check("pkt req seen", m_w_req, 1);
        check("pkt grant", grant_id, g);
        m_w_ack = 1'b1;
        #1;
        check("pkt ack", s_w_ack, 1 << g);
        cyc();
        m_w_ack = 1'b0;
        if (drop) s_w_req[g] = 1'b0;
    endtask

    task automatic run_pkt(input int g, input int len, input logic [31:0] base,
                           input bit drop, output int gap);
        grant_ack(g, drop, gap);
        for (int i = 0; i < len; i++) begin
            s_w_enable[g] = 1'b1;
            s_w_data[32*g +: 32] = base + 32'(i);
            cyc();
        end
        s_w_enable[g] = 1'b0;
        s_w_data[32*g +: 32] = '0;
    endtask

    int gap, words_before;
    int ast[N], adly[N], alen[N];
    logic ackd[N];

    initial begin
        rst = 1'b1; s_w_req = '0; s_w_enable = '0; s_w_data = '0; m_w_ack = 1'b0;
        cyc(); cyc();
        #1;
        check("rst grant_id", grant_id, 0);
        check("rst busy", busy, 0);
        check("rst m_w_req", m_w_req, 0);
        check("rst m_w_enable", m_w_enable, 0);
        check("rst timeout_cnt", timeout_cnt, 0);
        rst = 1'b0;

        // Single source 0, ack three cycles after request, 200-word packet
        s_w_req = 3'b001;
        #1 check("t1 idle", busy, 0);
        cyc(); #1;
        check("t1 m_w_req", m_w_req, 1);
        check("t1 grant", grant_id, 0);
        cyc(); cyc();
        m_w_ack = 1'b1;
        #1 check("t1 ack", s_w_ack, 3'b001);
        cyc();
        m_w_ack = 1'b0; s_w_req = '0;
        #1;
        check("t1 req low", m_w_req, 0);
        check("t1 busy", busy, 1);
        words_before = out_words;
        for (int i = 0; i < 200; i++) begin
            s_w_enable[0] = 1'b1;
            s_w_data[31:0] = 32'(i);
            #1;
            if (i > 0) begin
                check("t1 word en", m_w_enable, 1);
                check("t1 word", m_w_data, 32'(i - 1));
            end
            cyc();
        end
        s_w_enable[0] = 1'b0; s_w_data[31:0] = '0;
        #1;
        check("t1 last en", m_w_enable, 1);
        check("t1 last word", m_w_data, 32'h000000C7);
        cyc(); #1;
        check("t1 gap en", m_w_enable, 0);
        check("t1 gap busy", busy, 1);
        cyc(); #1;
        check("t1 done busy", busy, 0);
        check("t1 word count", out_words - words_before, 200);

        // Two continuous requesters alternate; last grant was 0 so 1 goes first
        s_w_req = 3'b011;
        for (int p = 0; p < 4; p++) begin
            run_pkt((p % 2 == 0) ? 1 : 0, 5, 32'h100 * 32'(p), 1'b0, gap);
            if (p > 0) check("rr gap", gap, 3);
        end
        s_w_req = '0;

        // Source 1 babbles while source 0 owns the port
        watch = 1'b1; beef_hits = 0;
        s_w_enable[1] = 1'b1; s_w_data[63:32] = 32'hDEADBEEF; s_w_req = 3'b001;
        run_pkt(0, 6, 32'h5000, 1'b1, gap);
        repeat (3) cyc();
        watch = 1'b0;
        check("beef hits", beef_hits, 0);
        s_w_enable[1] = 1'b0; s_w_data[63:32] = '0;

        // Source 0 acked but silent: timeout, then source 1 served
        s_w_req = 3'b001;
        grant_ack(0, 1'b1, gap);
        s_w_req = 3'b010;
        #1 check("to wait busy", busy, 1);
        repeat (7) cyc();
        #1;
        check("to before", timeout_cnt, 0);
        check("to before busy", busy, 1);
        cyc(); #1;
        check("to count", timeout_cnt, 1);
        check("to gap busy", busy, 1);
        cyc(); #1;
        check("to idle", busy, 0);
        run_pkt(1, 3, 32'h7000, 1'b1, gap);

        // Withdrawal before ack, then ack with same-cycle withdrawal
        repeat (2) cyc();
        s_w_req = 3'b001;
        cyc(); #1;
        check("wd req", m_w_req, 1);
        check("wd grant", grant_id, 0);
        s_w_req = '0;
        #1 check("wd no ack", s_w_ack, 0);
        cyc(); #1;
        check("wd idle", busy, 0);
        s_w_req = 3'b001;
        cyc();
        m_w_ack = 1'b1; s_w_req = '0;
        #1 check("wd ack", s_w_ack, 3'b001);
        cyc();
        m_w_ack = 1'b0;
        #1;
        check("wd wait busy", busy, 1);
        check("wd wait req", m_w_req, 0);
        s_w_enable[0] = 1'b1; s_w_data[31:0] = 32'h11;
        cyc(); cyc();
        s_w_enable[0] = 1'b0; s_w_data[31:0] = '0;
        repeat (3) cyc();

        // Reset at word 50 of a 200-word packet
        s_w_req = 3'b001;
        grant_ack(0, 1'b1, gap);
        for (int i = 0; i <= 50; i++) begin
            s_w_enable[0] = 1'b1;
            s_w_data[31:0] = 32'(i);
            if (i == 50) rst = 1'b1;
            cyc();
        end
        #1;
        check("mid rst en", m_w_enable, 0);
        check("mid rst data", m_w_data, 0);
        check("mid rst busy", busy, 0);
        check("mid rst to", timeout_cnt, 0);
        rst = 1'b0; s_w_enable = '0; s_w_data = '0;
        s_w_req = 3'b011;
        run_pkt(0, 4, 32'hA000, 1'b0, gap);
        s_w_req = '0;
        repeat (3) cyc();

        // Random agents: request, await ack, random delay, random burst
        for (int i = 0; i < N; i++) begin ast[i] = 0; adly[i] = 0; alen[i] = 0; ackd[i] = 1'b0; end
        for (int c = 0; c < 3000; c++) begin
            if (rst) for (int i = 0; i < N; i++) ast[i] = 0;
            for (int i = 0; i < N; i++) begin
                case (ast[i])
                    0: if ($urandom_range(0, 3) == 0) ast[i] = 1;
                    1: begin
                        if (ackd[i]) begin ast[i] = 2; adly[i] = $urandom_range(0, 11); end
                        else if ($urandom_range(0, 39) == 0) ast[i] = 0;
                    end
                    2: begin
                        if (adly[i] == 0) begin ast[i] = 3; alen[i] = $urandom_range(1, 12); end
                        else adly[i]--;
                    end
                    default: begin
                        if (alen[i] <= 1) ast[i] = 0;
                        else alen[i]--;
                    end
                endcase
                s_w_req[i] = (ast[i] == 1);
                s_w_enable[i] = 1'b0;
                if (ast[i] == 3) begin
                    s_w_enable[i] = 1'b1;
                    s_w_data[32*i +: 32] = $urandom;
                end else if (ast[i] == 0 && $urandom_range(0, 9) == 0) begin
                    s_w_enable[i] = 1'b1;
                    s_w_data[32*i +: 32] = $urandom;
                end
            end
            m_w_ack = m_w_req && ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 599) == 0);
            #1;
            for (int i = 0; i < N; i++) ackd[i] = s_w_ack[i];
            cyc();
        end
        rst = 1'b0; s_w_req = '0; s_w_enable = '0; s_w_data = '0; m_w_ack = 1'b0;
        repeat (20) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, got timeout want completion");
        $fatal(1);
    end
endmodule
